brc_iter: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle branch comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, in signed or unsigned mode.
- Returns less/equal flags over a valid/ready handshake.
- Sits beside the execute stage for wide-operand compares where a full-width carry chain does not meet timing.

---
 rtl/brc_iter.sv | 103 ++++++++++
 tb/tb_brc_iter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/brc_iter.sv
// brc_iter: multi-cycle chunked comparator producing less/equal flags, MSB chunk first
// Ports: i_clk/i_rst (sync active-high), i_flush aborts; request i_valid/o_ready with
// i_rs1_data, i_rs2_data, i_br_un; result o_valid/i_ready with o_br_less, o_br_equal.
// Optional macro BRC_ITER_EARLY_EXIT_EN: stop at the first differing chunk (variable latency).
module brc_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_br_un,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  generate
    if (WIDTH % CHUNK != 0) begin : g_bad
      $error("brc_iter: WIDTH must be a multiple of CHUNK");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] ac [NCHUNK];
  logic [CHUNK-1:0] bc [NCHUNK];
  logic [CHUNK-1:0] ca, cb;
  genvar g;
  for (g = 0; g < NCHUNK; g++) begin : g_ch
    assign ac[g] = a[g*CHUNK +: CHUNK];
    assign bc[g] = b[g*CHUNK +: CHUNK];
  end
  assign ca = ac[idx];
  assign cb = bc[idx];
`ifndef BRC_ITER_EARLY_EXIT_EN
  // sticky record of the most significant differing chunk while lower chunks are stepped
  logic dec, dl;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      o_br_less <= 1'b0;
      o_br_equal <= 1'b0;
      idx <= '0;
    end else if (i_flush) begin
      state <= IDLE;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          // flipping both sign bits maps two's complement order onto unsigned order
          a <= i_br_un ? i_rs1_data : i_rs1_data ^ MSB;
          b <= i_br_un ? i_rs2_data : i_rs2_data ^ MSB;
          idx <= IW'(NCHUNK - 1);
          o_ready <= 1'b0;
          state <= CMP;
`ifndef BRC_ITER_EARLY_EXIT_EN
          dec <= 1'b0;
`endif
        end
        CMP: begin
`ifdef BRC_ITER_EARLY_EXIT_EN
          if (ca != cb || idx == '0) begin
            o_br_less <= ca < cb;
            o_br_equal <= ca == cb;
            o_valid <= 1'b1;
            state <= DONE;
          end else idx <= idx - 1'b1;
`else
          if (!dec && ca != cb) begin
            dec <= 1'b1;
            dl <= ca < cb;
          end
          if (idx == '0) begin
            o_br_less <= dec ? dl : ca < cb;
            o_br_equal <= !dec && ca == cb;
            o_valid <= 1'b1;
            state <= DONE;
          end else idx <= idx - 1'b1;
`endif
        end
        DONE: if (i_ready) begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_brc_iter.sv
// tb_brc_iter: directed and randomized checks of brc_iter against an arithmetic reference
module tb_brc_iter;
  localparam int NCH = 4;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0, br_un = 1'b0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic o_ready, o_valid, less, equal;
  logic last_l = 1'b0, last_e = 1'b0;
  int checks = 0, failures = 0;
  brc_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un), .o_valid(o_valid),
    .i_ready(i_ready), .o_br_less(less), .o_br_equal(equal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [31:0] a, input logic [31:0] b, input logic un, input int hold);
    int k, cnt, first;
    logic el, ee;
    el = un ? (a < b) : ($signed(a) < $signed(b));
    ee = (a == b);
    first = -1;
    for (int i = NCH - 1; i >= 0; i--)
      if (first < 0 && a[i*8 +: 8] != b[i*8 +: 8]) first = i;
`ifdef BRC_ITER_EARLY_EXIT_EN
    k = first < 0 ? NCH : NCH - first;
`else
    k = NCH;
`endif
    chk("ready_idle", o_ready, 1);
    rs1 = a; rs2 = b; br_un = un; i_valid = 1'b1;
    tick();
    i_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; br_un = 1'($urandom);
    cnt = 0;
    while (!o_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("latency", cnt, k);
    chk("less", less, el);
    chk("equal", equal, ee);
    chk("ready_busy", o_ready, 0);
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1;
      tick();
      chk("bp_valid", o_valid, 1);
      chk("bp_less", less, el);
      chk("bp_equal", equal, ee);
      chk("bp_ready", o_ready, 0);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("rel_valid", o_valid, 0);
    chk("rel_ready", o_ready, 1);
    chk("hold_less", less, el);
    chk("hold_equal", equal, ee);
    last_l = el; last_e = ee;
  endtask
  initial begin
    logic [31:0] a, b;
    int sel;
    tick(); tick();
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_less", less, 0);
    chk("rst_equal", equal, 0);
    rst = 1'b0;
    tick();
    req(32'h12345678, 32'h12345678, 1'b1, 0);
    req(32'h80000000, 32'h00000001, 1'b0, 0);
    req(32'h80000000, 32'h00000001, 1'b1, 0);
    req(32'h000000FE, 32'h000000FF, 1'b1, 0);
    req(32'h000000FF, 32'h000000FE, 1'b1, 0);
    req(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 3);
    // flush on the second compare cycle
    rs1 = 32'h1; rs2 = 32'h2; br_un = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", o_ready, 1);
    chk("flush_valid", o_valid, 0);
    chk("flush_less", less, last_l);
    chk("flush_equal", equal, last_e);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_quiet", o_valid, 0);
    end
    // reset mid-compare
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ready", o_ready, 1);
    chk("mrst_valid", o_valid, 0);
    chk("mrst_less", less, 0);
    chk("mrst_equal", equal, 0);
    last_l = 1'b0; last_e = 1'b0;
    // flush coincident with a request is not an accept
    i_valid = 1'b1; flush = 1'b1;
    tick();
    i_valid = 1'b0; flush = 1'b0;
    chk("cflush_ready", o_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cflush_quiet", o_valid, 0);
    end
    // flush in DONE drops the result even with i_ready
    rs1 = 32'h0; rs2 = 32'h5; br_un = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 40 && !o_valid; i++) tick();
    chk("dflush_pre", o_valid, 1);
    flush = 1'b1; i_ready = 1'b1;
    tick();
    flush = 1'b0; i_ready = 1'b0;
    chk("dflush_valid", o_valid, 0);
    chk("dflush_ready", o_ready, 1);
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      sel = $urandom_range(0, 3);
      b = sel == 0 ? 32'($urandom) : sel == 1 ? a : a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
      req(a, b, 1'($urandom), $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
